booth_mult_arbiter: RTL and testbench
=====================================

BOOTH_MULT_ARBITER -- requirements
Module: booth_mult_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width; product width is 2*WIDTH.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters (2..16).
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum cycles to wait for multiplier completion.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  in  NUM_REQ  per-requester operation request.
REQ-007 SHALL have port req_ready  out  NUM_REQ  per-requester acceptance.
REQ-008 SHALL have port req_multiplier  in  NUM_REQ*WIDTH  packed operands; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port req_multiplicand  in  NUM_REQ*WIDTH  packed operands, same packing.
REQ-010 SHALL have port resp_valid  out  1  result available.
REQ-011 SHALL have port resp_ready  in  1  result consumer acceptance.
REQ-012 SHALL have port resp_id  out  clog2(NUM_REQ)  index of the requester owning the result.
REQ-013 SHALL have port resp_product  out  2*WIDTH  result bits.
REQ-014 SHALL have port resp_err  out  1  result is invalid because of timeout.
REQ-015 SHALL have ports mult_en out 1, mult_start out 1, mult_multiplier out WIDTH, mult_multiplicand out WIDTH, mult_ready in 1, mult_product in 2*WIDTH, connecting to one shared sequential booth multiplier.

Function
REQ-016 SHALL implement FSM states IDLE, START, BUSY, RESP.
REQ-017 IDLE: SHALL assert req_ready only for the round-robin winner among asserted req_valid bits, zero or one bit high, never depending on resp_ready.
REQ-018 Round-robin: search SHALL begin at index (last_grant+1) mod NUM_REQ and wrap; last_grant resets to NUM_REQ-1, so requester 0 wins first.
REQ-019 On req_valid[i] & req_ready[i]: SHALL capture both operands and id i into registers, update last_grant to i, and go to START.
REQ-020 START: SHALL drive mult_start=1 for exactly one cycle, then go to BUSY.
REQ-021 mult_multiplier/mult_multiplicand SHALL come from the captured registers and stay stable from START until leaving BUSY.
REQ-022 mult_en SHALL be 1 in START and BUSY, 0 otherwise.
REQ-023 BUSY: SHALL ignore mult_ready in the first BUSY cycle; thereafter mult_ready=1 SHALL capture mult_product into resp_product, set resp_err=0, and go to RESP.
REQ-024 BUSY SHALL count cycles; if the count reaches TIMEOUT without a qualified mult_ready, SHALL set resp_product=0, resp_err=1, and go to RESP.
REQ-025 RESP: SHALL hold resp_valid=1 with stable resp_id/resp_product/resp_err until resp_ready=1; on that cycle SHALL return to IDLE.
REQ-026 req_ready SHALL be 0 in START, BUSY and RESP; new requests SHALL not be accepted until the next IDLE cycle, giving one idle cycle between jobs.
REQ-027 Product bits SHALL pass through unmodified; no sign or width conversion.
REQ-028 A requester deasserting req_valid before acceptance SHALL lose nothing; arbitration is re-evaluated every IDLE cycle.
REQ-029 Latency from acceptance to resp_valid SHALL be multiplier latency plus 2 cycles.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, last_grant=NUM_REQ-1, counter 0, and req_ready, resp_valid, resp_err, mult_start, mult_en to 0.
REQ-031 rst_n=0 SHALL also force resp_id, resp_product, mult_multiplier and mult_multiplicand to 0.
REQ-032 Reset mid-operation SHALL abandon the job without a response; after release, the first grant goes to requester 0.

Verification
REQ-033 Requester 2 only, operands 3 and 5, resp_ready=1 -> one mult_start pulse; resp_valid with resp_id=2, resp_product=16'h000F, resp_err=0.
REQ-034 All four requesters valid continuously -> grants in order 0,1,2,3,0; exactly one req_ready bit high per IDLE cycle.
REQ-035 Operands 8'hFD and 8'h05 (signed -3*5), resp_ready held 0 for 10 cycles -> resp_product=16'hFFF1 stable throughout; no new req_ready until one cycle after resp_ready=1.
REQ-036 Multiplier model never asserts mult_ready -> after TIMEOUT (64) BUSY cycles: resp_valid=1, resp_err=1, resp_product=0; the next request proceeds normally.
REQ-037 rst_n pulsed low during BUSY -> all outputs 0 asynchronously, no response emitted; next grant is requester 0.
REQ-038 Stale mult_ready=1 held high before START -> ignored in the first BUSY cycle; result is taken no earlier than the second BUSY cycle.

Source files
------------

// File: rtl/booth_mult_arbiter.sv
// Round-robin front end that shares one sequential Booth multiplier among NUM_REQ requesters.
// Each job is started, watched for completion or timeout, and its result is held until consumed.
module booth_mult_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_multiplier,
    input  logic [NUM_REQ*WIDTH-1:0]   req_multiplicand,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic [2*WIDTH-1:0]         resp_product,
    output logic                       resp_err,
    output logic                       mult_en,
    output logic                       mult_start,
    output logic [WIDTH-1:0]           mult_multiplier,
    output logic [WIDTH-1:0]           mult_multiplicand,
    input  logic                       mult_ready,
    input  logic [2*WIDTH-1:0]         mult_product
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, BUSY, RESP} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [ID_W-1:0]    r_last_grant;
    logic [ID_W-1:0]    r_id;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_mcand;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_product;
    logic               r_err;

    logic               w_found;
    logic [ID_W-1:0]    w_grant_idx;
    logic               w_accept;
    logic               w_mult_done;
    int                 w_idx;

    // Rotating priority search starting just after the previous winner.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(r_last_grant) + 1 + k) % NUM_REQ;
            if (!w_found && req_valid[w_idx]) begin
                w_found     = 1'b1;
                w_grant_idx = ID_W'(w_idx);
            end
        end
    end

    // rst_n gates the grant so req_ready drops the instant reset is asserted.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = rst_n && (r_state == IDLE) && w_found
                                   && (w_grant_idx == ID_W'(gi));
        end
    endgenerate

    assign w_accept    = |(req_valid & req_ready);
    assign w_mult_done = (r_cnt != '0) && mult_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = START;
            START:   w_state_next = BUSY;
            BUSY:    if (w_mult_done || (r_cnt == CNT_LAST)) w_state_next = RESP;
            RESP:    if (resp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_id         <= '0;
            r_mplier     <= '0;
            r_mcand      <= '0;
            r_cnt        <= '0;
            r_product    <= '0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_id         <= w_grant_idx;
                        r_last_grant <= w_grant_idx;
                        r_mplier     <= req_multiplier[w_grant_idx*WIDTH +: WIDTH];
                        r_mcand      <= req_multiplicand[w_grant_idx*WIDTH +: WIDTH];
                    end
                end
                START: r_cnt <= '0;
                BUSY: begin
                    // A ready seen while r_cnt is still zero may be left over from a previous job.
                    if (w_mult_done) begin
                        r_product <= mult_product;
                        r_err     <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_product <= '0;
                        r_err     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mult_start        = (r_state == START);
    assign mult_en           = (r_state == START) || (r_state == BUSY);
    assign mult_multiplier   = r_mplier;
    assign mult_multiplicand = r_mcand;
    assign resp_valid        = (r_state == RESP);
    assign resp_id           = r_id;
    assign resp_product      = r_product;
    assign resp_err          = r_err;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter with a behavioural signed multiplier of fixed latency.
module tb_booth_mult_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_multiplier;
    logic [31:0] req_multiplicand;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_id;
    logic [15:0] resp_product;
    logic        resp_err;
    logic        mult_en;
    logic        mult_start;
    logic [7:0]  mult_multiplier;
    logic [7:0]  mult_multiplicand;
    logic        mult_ready;
    logic [15:0] mult_product;

    int checks = 0;
    int errors = 0;

    // 0: normal (3-cycle latency), 1: never ready, 2: ready stuck high
    int          mode = 0;
    int          m_cnt = 0;
    logic        m_rdy = 1'b0;
    logic signed [15:0] m_prod_calc;

    booth_mult_arbiter #(.WIDTH(8), .NUM_REQ(4), .TIMEOUT(64)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_multiplier    (req_multiplier),
        .req_multiplicand  (req_multiplicand),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_id           (resp_id),
        .resp_product      (resp_product),
        .resp_err          (resp_err),
        .mult_en           (mult_en),
        .mult_start        (mult_start),
        .mult_multiplier   (mult_multiplier),
        .mult_multiplicand (mult_multiplicand),
        .mult_ready        (mult_ready),
        .mult_product      (mult_product)
    );

    always #5 clk = ~clk;

    assign m_prod_calc = $signed(mult_multiplier) * $signed(mult_multiplicand);
    assign mult_ready  = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : m_rdy;

    always @(posedge clk) begin
        if (mult_start) begin
            m_cnt        <= 3;
            m_rdy        <= 1'b0;
            mult_product <= m_prod_calc;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            m_rdy <= (m_cnt == 1);
        end
    end

    task automatic do_reset();
        rst_n      = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Waits (bounded) for a grant; called at a negedge with inputs already set.
    task automatic wait_grant(output logic [3:0] g, output int tries, output bit ok);
        ok = 1'b0;
        g  = '0;
        for (tries = 0; tries < 50; tries++) begin
            #1;
            if ((req_ready & req_valid) != 0) begin
                g  = req_ready;
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    // Starts at the negedge of the START cycle; returns at the first negedge with resp_valid.
    task automatic wait_resp(output int cyc, output int starts, output int busy, output bit ok);
        cyc    = 0;
        starts = 0;
        busy   = 0;
        ok     = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (resp_valid) begin
                ok = 1'b1;
                return;
            end
            if (mult_start) starts++;
            if (mult_en && !mult_start) busy++;
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        req_valid        = 4'b1111;
        resp_ready       = 1'b0;
        req_multiplier   = '0;
        req_multiplicand = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_err, mult_en, mult_start} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl got %b expected 00000000",
                     {req_ready, resp_valid, resp_err, mult_en, mult_start});
        end
        checks++;
        if ({resp_id, resp_product, mult_multiplier, mult_multiplicand} !== 34'h0) begin
            errors++;
            $display("FAIL reset_data got %h expected 0",
                     {resp_id, resp_product, mult_multiplier, mult_multiplicand});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_grant got %b expected 0001", req_ready);
        end
        req_valid = '0;
        $display("reset: outputs cleared, first grant req_ready=%b", req_ready);
    endtask

    task automatic test_single();
        logic [3:0] g;
        int tries, cyc, starts, busy;
        bit ok;
        do_reset();
        req_multiplier       = '0;
        req_multiplicand     = '0;
        req_multiplier[16+:8]   = 8'd3;
        req_multiplicand[16+:8] = 8'd5;
        req_valid  = 4'b0100;
        resp_ready = 1'b1;
        wait_grant(g, tries, ok);
        checks++;
        if (!ok || g !== 4'b0100) begin
            errors++;
            $display("FAIL single_grant got %b expected 0100", g);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        wait_resp(cyc, starts, busy, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_resp_timeout got no resp_valid expected resp_valid=1");
        end
        checks++;
        if (starts !== 1) begin
            errors++;
            $display("FAIL single_start_pulses got %0d expected 1", starts);
        end
        checks++;
        if (resp_id !== 2'd2 || resp_product !== 16'h000F || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL single_result got id=%0d p=%h err=%b expected id=2 p=000f err=0",
                     resp_id, resp_product, resp_err);
        end
        checks++;
        if (cyc !== 5) begin
            errors++;
            $display("FAIL single_latency got %0d expected 5", cyc);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_resp_consumed got %b expected 0", resp_valid);
        end
        $display("single: id=%0d product=%h err=%b latency=%0d", resp_id, resp_product, resp_err, cyc);
    endtask

    task automatic test_round_robin();
        logic [3:0]  g;
        logic [15:0] exp_p [4];
        logic [3:0]  exp_g;
        int tries, cyc, starts, busy;
        bit ok;
        exp_p[0] = 16'h0006;
        exp_p[1] = 16'h000C;
        exp_p[2] = 16'h0014;
        exp_p[3] = 16'h001E;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_multiplier[i*8+:8]   = 8'(i + 2);
            req_multiplicand[i*8+:8] = 8'(i + 3);
        end
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            wait_grant(g, tries, ok);
            checks++;
            if (!ok || g !== exp_g || (k > 0 && tries != 0)) begin
                errors++;
                $display("FAIL rr_grant%0d got %b tries=%0d expected %b tries=0", k, g, tries, exp_g);
            end
            @(posedge clk);
            @(negedge clk);
            wait_resp(cyc, starts, busy, ok);
            checks++;
            if (!ok || resp_id !== 2'(k % 4) || resp_product !== exp_p[k % 4]) begin
                errors++;
                $display("FAIL rr_result%0d got id=%0d p=%h expected id=%0d p=%h",
                         k, resp_id, resp_product, k % 4, exp_p[k % 4]);
            end
            $display("rr: job %0d grant=%b id=%0d product=%h", k, g, resp_id, resp_product);
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [3:0] g;
        int tries, cyc, starts, busy;
        bit ok;
        int bad;
        do_reset();
        req_multiplier[0+:8]   = 8'hFD;
        req_multiplicand[0+:8] = 8'h05;
        req_multiplier[8+:8]   = 8'h02;
        req_multiplicand[8+:8] = 8'h02;
        req_valid  = 4'b0011;
        resp_ready = 1'b0;
        wait_grant(g, tries, ok);
        checks++;
        if (!ok || g !== 4'b0001) begin
            errors++;
            $display("FAIL bp_grant got %b expected 0001", g);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0010;
        wait_resp(cyc, starts, busy, ok);
        checks++;
        if (!ok || resp_product !== 16'hFFF1 || resp_id !== 2'd0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL bp_result got p=%h id=%0d err=%b expected p=fff1 id=0 err=0",
                     resp_product, resp_id, resp_err);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (resp_valid !== 1'b1 || resp_product !== 16'hFFF1 || req_ready !== 4'b0000) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold got %0d unstable cycles expected 0", bad);
        end
        resp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000 || resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_handshake_cycle got ready=%b valid=%b expected ready=0000 valid=1",
                     req_ready, resp_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_next_grant got %b expected 0010", req_ready);
        end
        req_valid = '0;
        $display("backpressure: product=fff1 held 10 cycles, next grant=%b", req_ready);
    endtask

    task automatic test_timeout();
        logic [3:0] g;
        int tries, cyc, starts, busy;
        bit ok;
        do_reset();
        mode = 1;
        req_multiplier[24+:8]   = 8'd9;
        req_multiplicand[24+:8] = 8'd9;
        req_valid  = 4'b1000;
        resp_ready = 1'b0;
        wait_grant(g, tries, ok);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        wait_resp(cyc, starts, busy, ok);
        checks++;
        if (!ok || busy !== 64) begin
            errors++;
            $display("FAIL to_busy_cycles got %0d ok=%b expected 64", busy, ok);
        end
        checks++;
        if (resp_err !== 1'b1 || resp_product !== 16'h0000 || resp_id !== 2'd3) begin
            errors++;
            $display("FAIL to_result got err=%b p=%h id=%0d expected err=1 p=0000 id=3",
                     resp_err, resp_product, resp_id);
        end
        $display("timeout: busy=%0d err=%b product=%h", busy, resp_err, resp_product);
        mode       = 0;
        resp_ready = 1'b1;
        @(negedge clk);
        req_multiplier[0+:8]   = 8'd7;
        req_multiplicand[0+:8] = 8'd9;
        req_valid = 4'b0001;
        wait_grant(g, tries, ok);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        wait_resp(cyc, starts, busy, ok);
        checks++;
        if (!ok || resp_err !== 1'b0 || resp_product !== 16'h003F || resp_id !== 2'd0) begin
            errors++;
            $display("FAIL to_recover got err=%b p=%h id=%0d expected err=0 p=003f id=0",
                     resp_err, resp_product, resp_id);
        end
        $display("timeout: recovery job product=%h", resp_product);
        @(negedge clk);
    endtask

    task automatic test_reset_busy();
        logic [3:0] g;
        int tries;
        bit ok;
        bit seen;
        req_multiplier[8+:8]   = 8'h11;
        req_multiplicand[8+:8] = 8'h22;
        req_valid = 4'b0010;
        wait_grant(g, tries, ok);
        checks++;
        if (!ok || g !== 4'b0010) begin
            errors++;
            $display("FAIL rb_grant got %b expected 0010", g);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0110;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_err, mult_en, mult_start} !== 8'h00) begin
            errors++;
            $display("FAIL rb_ctrl got %b expected 00000000",
                     {req_ready, resp_valid, resp_err, mult_en, mult_start});
        end
        checks++;
        if ({resp_id, resp_product, mult_multiplier, mult_multiplicand} !== 34'h0) begin
            errors++;
            $display("FAIL rb_data got %h expected 0",
                     {resp_id, resp_product, mult_multiplier, mult_multiplicand});
        end
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = '0;
        seen      = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rb_no_resp got resp_valid=1 expected 0");
        end
        req_valid = 4'b0101;
        wait_grant(g, tries, ok);
        checks++;
        if (!ok || g !== 4'b0001) begin
            errors++;
            $display("FAIL rb_next_grant got %b expected 0001", g);
        end
        req_valid = '0;
        $display("reset_busy: job abandoned, next grant=%b", g);
    endtask

    task automatic test_stale_ready();
        logic [3:0] g;
        int tries, cyc, starts, busy;
        bit ok;
        do_reset();
        mode = 2;
        req_multiplier[16+:8]   = 8'd6;
        req_multiplicand[16+:8] = 8'd7;
        req_valid = 4'b0100;
        wait_grant(g, tries, ok);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        wait_resp(cyc, starts, busy, ok);
        checks++;
        if (!ok || cyc !== 3) begin
            errors++;
            $display("FAIL stale_latency got %0d expected 3", cyc);
        end
        checks++;
        if (resp_product !== 16'h002A || resp_id !== 2'd2 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL stale_result got p=%h id=%0d err=%b expected p=002a id=2 err=0",
                     resp_product, resp_id, resp_err);
        end
        $display("stale_ready: latency=%0d product=%h", cyc, resp_product);
        mode = 0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_reset_busy();
        test_stale_ready();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
